// File: rtl/usb4_lane_block_encoder_if.sv
// Lane-adapter / serializer handshake bundle for usb4_lane_block_encoder.
// The source side (adapter + serializer) uses master; the encoder uses slave.
interface usb4_lane_block_encoder_if #(
  parameter int NUM_LANES = 2,
  parameter int BLK_W     = 132
);
  logic                       enable;
  logic [1:0]                 gen_speed;
  logic [3:0]                 d_sel;
  logic [8*NUM_LANES-1:0]     lane_tx;
  logic                       in_valid;
  logic                       in_ready;
  logic [BLK_W*NUM_LANES-1:0] blk_data;
  logic [1:0]                 blk_len;
  logic                       blk_valid;
  logic                       blk_ready;
  logic                       new_sym;
  logic                       overflow;

  modport master (
    output enable, gen_speed, d_sel, lane_tx, in_valid, blk_ready,
    input  in_ready, blk_data, blk_len, blk_valid, new_sym, overflow
  );

  modport slave (
    input  enable, gen_speed, d_sel, lane_tx, in_valid, blk_ready,
    output in_ready, blk_data, blk_len, blk_valid, new_sym, overflow
  );
endinterface

// File: rtl/usb4_lane_block_encoder.sv
// N-lane USB4 transmit block encoder: Gen2 66b blocks, Gen3 132b blocks, Gen4 byte bypass.
// Define ENC_SCRAMBLE_EN to add a per-lane payload scrambler.
module usb4_lane_block_encoder #(
  parameter int NUM_LANES = 2,
  parameter int BLK_W     = 132
) (
  input logic                      enc_clk,
  input logic                      rst,
  usb4_lane_block_encoder_if.slave enc
);

  typedef enum logic {COLLECT, HOLD} state_t;

  localparam logic [3:0] DSEL_DATA = 4'd8;
  localparam logic [3:0] DSEL_NONE = 4'd9;
  localparam logic [1:0] SPD_GEN4  = 2'd0;
  localparam logic [1:0] SPD_GEN3  = 2'd1;
  localparam logic [1:0] SPD_GEN2  = 2'd2;

  state_t                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [1:0]                 spd_q;
  logic                       is_data_q;
  logic [127:0]               buf_q  [NUM_LANES];
  logic [127:0]               buf_wr [NUM_LANES];
  logic [7:0]                 pay    [NUM_LANES];
  logic [BLK_W*NUM_LANES-1:0] blk_enc, byte_enc, blk_data_q;
  logic [1:0]                 blk_len_q;
  logic                       blk_valid_q, new_sym_q, overflow_q;

  logic speed_chg, is_gen4, is_gen3, is_blk, out_free;
  logic in_ready_c, offered, accept, last_byte;
  logic load_blk, load_byte;

  assign speed_chg = enc.gen_speed != spd_q;
  assign is_gen4   = enc.gen_speed == SPD_GEN4;
  assign is_gen3   = enc.gen_speed == SPD_GEN3;
  assign is_blk    = is_gen3 || (enc.gen_speed == SPD_GEN2);
  assign out_free  = !blk_valid_q || enc.blk_ready;
  assign offered   = enc.in_valid && (enc.d_sel != DSEL_NONE);
  assign accept    = offered && in_ready_c;
  assign last_byte = cnt_q == (is_gen3 ? 4'd15 : 4'd7);

  // Speed 3 (reserved) and the cycle of any speed change leave in_ready low.
  always_comb begin
    in_ready_c = 1'b0;
    if (rst && enc.enable && !speed_chg) begin
      if (is_gen4)     in_ready_c = out_free;
      else if (is_blk) in_ready_c = (state_q == COLLECT);
    end
  end

`ifdef ENC_SCRAMBLE_EN
  localparam logic [22:0] SEED_L0 = 23'h1DBFBC;
  localparam logic [22:0] SEED_L1 = 23'h0607BB;

  logic [22:0] lfsr_q  [NUM_LANES];
  logic [22:0] lfsr_nx [NUM_LANES];
  logic [7:0]  key     [NUM_LANES];

  function automatic logic [22:0] lane_seed(input int k);
    return (k == 1) ? SEED_L1 : (SEED_L0 ^ 23'(k));
  endfunction

  // x^23+x^21+x^16+x^8+x^5+x^2+1, eight steps per accepted byte, key bit 0 first.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      key[k]     = '0;
      lfsr_nx[k] = lfsr_q[k];
      for (int j = 0; j < 8; j++) begin
        key[k][j]  = lfsr_nx[k][22];
        lfsr_nx[k] = {lfsr_nx[k][21:0], lfsr_nx[k][22] ^ lfsr_nx[k][20] ^ lfsr_nx[k][15]
                                       ^ lfsr_nx[k][7] ^ lfsr_nx[k][4] ^ lfsr_nx[k][1]};
      end
      pay[k] = enc.lane_tx[8*k +: 8] ^ key[k];
    end
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_LANES; k++) lfsr_q[k] <= lane_seed(k);
    end else if (!enc.enable || speed_chg) begin
      for (int k = 0; k < NUM_LANES; k++) lfsr_q[k] <= lane_seed(k);
    end else if (accept && is_blk) begin
      for (int k = 0; k < NUM_LANES; k++) lfsr_q[k] <= lfsr_nx[k];
    end
  end
`else
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) pay[k] = enc.lane_tx[8*k +: 8];
  end
`endif

  function automatic logic [BLK_W-1:0] encode(input logic [127:0] b, input logic gen3,
                                              input logic data);
    if (gen3) return BLK_W'({b, data ? 4'b1010 : 4'b0101});
    return BLK_W'({b[63:0], data ? 2'b10 : 2'b01});
  endfunction

  // NOTE: combinational blocks use blocking '=' so later statements see the updated value.
  always_comb begin
    blk_enc  = '0;
    byte_enc = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      buf_wr[k] = buf_q[k];
      buf_wr[k][{cnt_q, 3'b000} +: 8] = pay[k];
      // A held block is already complete in buf_q; buf_wr would overwrite byte cnt.
      blk_enc[BLK_W*k +: BLK_W]  = encode((state_q == HOLD) ? buf_q[k] : buf_wr[k],
                                          is_gen3, is_data_q);
      byte_enc[BLK_W*k +: BLK_W] = BLK_W'(enc.lane_tx[8*k +: 8]);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_blk  = 1'b0;
    load_byte = 1'b0;
    if (speed_chg) begin
      state_d = COLLECT;
      cnt_d   = '0;
    end else if (is_gen4) begin
      load_byte = accept;
    end else if (is_blk) begin
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            if (last_byte) begin
              cnt_d = '0;
              if (out_free) load_blk = 1'b1;
              else          state_d  = HOLD;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        HOLD: begin
          if (enc.blk_ready) begin
            load_blk = 1'b1;
            state_d  = COLLECT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      spd_q       <= '0;
      is_data_q   <= 1'b0;
      blk_data_q  <= '0;
      blk_len_q   <= '0;
      blk_valid_q <= 1'b0;
      new_sym_q   <= 1'b0;
      overflow_q  <= 1'b0;
      // NOTE: the collection buffer is reset explicitly because it is defined to read 0 after reset.
      for (int k = 0; k < NUM_LANES; k++) buf_q[k] <= '0;
    end else if (!enc.enable) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      spd_q       <= enc.gen_speed;
      is_data_q   <= 1'b0;
      blk_data_q  <= '0;
      blk_len_q   <= '0;
      blk_valid_q <= 1'b0;
      new_sym_q   <= 1'b0;
      overflow_q  <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) buf_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      spd_q     <= enc.gen_speed;
      new_sym_q <= accept && (is_gen4 || cnt_q == 4'd0);
      if (offered && !in_ready_c) overflow_q <= 1'b1;
      if (accept && is_blk) begin
        for (int k = 0; k < NUM_LANES; k++) buf_q[k] <= buf_wr[k];
        if (cnt_q == 4'd0) is_data_q <= (enc.d_sel == DSEL_DATA);
      end
      if (load_blk) begin
        blk_data_q  <= blk_enc;
        blk_len_q   <= is_gen3 ? 2'd2 : 2'd1;
        blk_valid_q <= 1'b1;
      end else if (load_byte) begin
        blk_data_q  <= byte_enc;
        blk_len_q   <= 2'd0;
        blk_valid_q <= 1'b1;
      end else if (blk_valid_q && enc.blk_ready) begin
        blk_valid_q <= 1'b0;
      end
    end
  end

  assign enc.in_ready  = in_ready_c;
  assign enc.blk_data  = blk_data_q;
  assign enc.blk_len   = blk_len_q;
  assign enc.blk_valid = blk_valid_q;
  assign enc.new_sym   = new_sym_q;
  assign enc.overflow  = overflow_q;

endmodule

// File: tb/tb_usb4_lane_block_encoder.sv
// Directed bench for usb4_lane_block_encoder: Gen4 vector table plus Gen2/Gen3 sequences.
// With ENC_SCRAMBLE_EN defined, expected payloads pass through a reference scrambler.
module tb_usb4_lane_block_encoder;
  localparam int NL = 2;
  localparam int BW = 132;
  localparam int DW = NL * BW;

  typedef struct {
    logic [3:0]  d_sel;
    logic [15:0] lanes;
    logic        exp_valid;
    logic        exp_sym;
    logic [7:0]  exp_b0;
    logic [7:0]  exp_b1;
  } g4_vec_t;

  logic          enc_clk = 1'b0;
  logic          rst;
  int            n_vec   = 0;
  int            n_bad   = 0;
  int            sym_cnt = 0;
  logic [127:0]  exp_p0, exp_p1;
  logic [DW-1:0] blk_a, blk_b;
  g4_vec_t       tbl [5];

  usb4_lane_block_encoder_if #(.NUM_LANES(NL), .BLK_W(BW)) bus ();

  usb4_lane_block_encoder #(.NUM_LANES(NL), .BLK_W(BW)) dut (
    .enc_clk (enc_clk),
    .rst     (rst),
    .enc     (bus)
  );

  always #5 enc_clk = ~enc_clk;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

`ifdef ENC_SCRAMBLE_EN
  localparam logic [22:0] TAPS = 23'h508092;
  logic [22:0] m_lfsr [NL];
`endif

  task automatic m_reseed();
`ifdef ENC_SCRAMBLE_EN
    m_lfsr[0] = 23'h1DBFBC;
    m_lfsr[1] = 23'h0607BB;
`endif
  endtask

  function automatic logic [15:0] pay2(input logic [15:0] b);
    logic [15:0] r;
    r = b;
`ifdef ENC_SCRAMBLE_EN
    for (int ln = 0; ln < NL; ln++)
      for (int j = 0; j < 8; j++) begin
        r[8*ln+j]  = r[8*ln+j] ^ m_lfsr[ln][22];
        m_lfsr[ln] = {m_lfsr[ln][21:0], ^(m_lfsr[ln] & TAPS)};
      end
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge enc_clk);
    #1;
  endtask

  task automatic send(input logic [3:0] ds, input logic [15:0] lanes);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge enc_clk);
      if (bus.in_ready) begin
        bus.d_sel    = ds;
        bus.lane_tx  = lanes;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        sym_cnt += int'(bus.new_sym);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 40 cycles");
    end
  endtask

  task automatic fill(input int i0, input int n, input logic [3:0] ds,
                      input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] step);
    logic [15:0] lanes, p;
    for (int i = i0; i < i0 + n; i++) begin
      lanes = {b1 + step * 8'(i), b0 + step * 8'(i)};
      send(ds, lanes);
      p = pay2(lanes);
      exp_p0[8*i +: 8] = p[7:0];
      exp_p1[8*i +: 8] = p[15:8];
    end
  endtask

  function automatic logic [DW-1:0] exp3(input logic data);
    logic [3:0] h;
    h = data ? 4'b1010 : 4'b0101;
    return {exp_p1, h, exp_p0, h};
  endfunction

  function automatic logic [DW-1:0] exp2(input logic data);
    logic [1:0] h;
    h = data ? 2'b10 : 2'b01;
    return {66'b0, exp_p1[63:0], h, 66'b0, exp_p0[63:0], h};
  endfunction

  initial begin
    tbl[0] = '{4'd8, 16'hA111, 1'b1, 1'b1, 8'h11, 8'hA1};
    tbl[1] = '{4'd8, 16'hB222, 1'b1, 1'b1, 8'h22, 8'hB2};
    tbl[2] = '{4'd9, 16'hFFFF, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[3] = '{4'd2, 16'h0080, 1'b1, 1'b1, 8'h80, 8'h00};
    tbl[4] = '{4'd8, 16'hFF7E, 1'b1, 1'b1, 8'h7E, 8'hFF};

    rst = 1'b0;
    bus.enable = 1'b1; bus.gen_speed = 2'd1; bus.d_sel = 4'd8;
    bus.lane_tx = '0; bus.in_valid = 1'b0; bus.blk_ready = 1'b1;
    exp_p0 = '0; exp_p1 = '0;
    m_reseed();
    #3;
    check("rst_valid",   DW'(bus.blk_valid), DW'(0));
    check("rst_data",    bus.blk_data,       DW'(0));
    check("rst_len",     DW'(bus.blk_len),   DW'(0));
    check("rst_ready",   DW'(bus.in_ready),  DW'(0));
    check("rst_new_sym", DW'(bus.new_sym),   DW'(0));
    check("rst_ovf",     DW'(bus.overflow),  DW'(0));
    @(negedge enc_clk);
    rst = 1'b1;

    // Gen3 data block, bytes 00..0F on lane0 (80..8F on lane1)
    sym_cnt = 0;
    fill(0, 15, 4'd8, 8'h00, 8'h80, 8'h01);
    check("g3_early_valid", DW'(bus.blk_valid), DW'(0));
    fill(15, 1, 4'd8, 8'h00, 8'h80, 8'h01);
    check("g3_valid",   DW'(bus.blk_valid), DW'(1));
    check("g3_len",     DW'(bus.blk_len),   DW'(2));
    check("g3_data",    bus.blk_data,       exp3(1'b1));
    check("g3_new_sym", DW'(sym_cnt),       DW'(1));
    tick();
    check("g3_drain", DW'(bus.blk_valid), DW'(0));

    // Gen2 ordered sets with serializer stalled: hold, backpressure, overflow
    @(negedge enc_clk);
    bus.gen_speed = 2'd2; bus.blk_ready = 1'b0; m_reseed();
    fill(0, 8, 4'd3, 8'hA5, 8'h5A, 8'h00);
    blk_a = exp2(1'b0);
    check("g2_first_data", bus.blk_data,     blk_a);
    check("g2_first_len",  DW'(bus.blk_len), DW'(1));
    fill(0, 8, 4'd3, 8'h3C, 8'hC3, 8'h01);
    blk_b = exp2(1'b0);
    @(negedge enc_clk);
    check("g2_hold_ready", DW'(bus.in_ready), DW'(0));
    repeat (10) @(negedge enc_clk);
    check("g2_hold_stable", bus.blk_data,       blk_a);
    check("g2_hold_valid",  DW'(bus.blk_valid), DW'(1));
    bus.d_sel = 4'd8; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("g2_overflow", DW'(bus.overflow), DW'(1));
    @(negedge enc_clk);
    bus.blk_ready = 1'b1;
    tick();
    check("g2_second_data",  bus.blk_data,       blk_b);
    check("g2_second_valid", DW'(bus.blk_valid), DW'(1));
    tick();
    check("g2_drain", DW'(bus.blk_valid), DW'(0));

    // Gen4 byte bypass vector table
    @(negedge enc_clk);
    bus.gen_speed = 2'd0; bus.blk_ready = 1'b1;
    @(negedge enc_clk);
    for (int v = 0; v < 5; v++) begin
      @(negedge enc_clk);
      check($sformatf("g4_ready_%0d", v), DW'(bus.in_ready), DW'(1));
      bus.d_sel = tbl[v].d_sel; bus.lane_tx = tbl[v].lanes; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check($sformatf("g4_valid_%0d", v), DW'(bus.blk_valid), DW'(tbl[v].exp_valid));
      check($sformatf("g4_sym_%0d", v),   DW'(bus.new_sym),   DW'(tbl[v].exp_sym));
      if (tbl[v].exp_valid) begin
        check($sformatf("g4_data_%0d", v), bus.blk_data,
              {124'b0, tbl[v].exp_b1, 124'b0, tbl[v].exp_b0});
        check($sformatf("g4_len_%0d", v), DW'(bus.blk_len), DW'(0));
      end
    end

    // Gen3 partial block discarded by a change to Gen2
    @(negedge enc_clk);
    bus.gen_speed = 2'd1; m_reseed();
    fill(0, 5, 4'd8, 8'hE0, 8'hF0, 8'h01);
    check("spd_no_blk", DW'(bus.blk_valid), DW'(0));
    bus.gen_speed = 2'd2; m_reseed();
    fill(0, 7, 4'd8, 8'h40, 8'h50, 8'h01);
    check("spd_partial", DW'(bus.blk_valid), DW'(0));
    fill(7, 1, 4'd8, 8'h40, 8'h50, 8'h01);
    check("spd_blk_data", bus.blk_data,     exp2(1'b1));
    check("spd_blk_len",  DW'(bus.blk_len), DW'(1));
    tick();

    // Synchronous flush mid-block with a pending block
    bus.blk_ready = 1'b0;
    fill(0, 8, 4'd8, 8'h01, 8'h02, 8'h03);
    check("fl_valid_before", DW'(bus.blk_valid), DW'(1));
    fill(0, 3, 4'd8, 8'h61, 8'h62, 8'h01);
    check("fl_ovf_before", DW'(bus.overflow), DW'(1));
    bus.enable = 1'b0;
    tick();
    check("fl_valid", DW'(bus.blk_valid), DW'(0));
    check("fl_ovf",   DW'(bus.overflow),  DW'(0));
    check("fl_data",  bus.blk_data,       DW'(0));
    check("fl_ready", DW'(bus.in_ready),  DW'(0));
    bus.enable = 1'b1; bus.blk_ready = 1'b1; m_reseed();
    fill(0, 7, 4'd8, 8'h90, 8'hA0, 8'h01);
    check("fl_cnt_partial", DW'(bus.blk_valid), DW'(0));
    fill(7, 1, 4'd8, 8'h90, 8'hA0, 8'h01);
    check("fl_cnt_block", bus.blk_data, exp2(1'b1));
    tick();

    // Asynchronous reset between clock edges
    bus.blk_ready = 1'b0;
    fill(0, 8, 4'd8, 8'h11, 8'h22, 8'h01);
    check("ar_valid_before", DW'(bus.blk_valid), DW'(1));
    #2 rst = 1'b0;
    #1;
    check("ar_valid", DW'(bus.blk_valid), DW'(0));
    check("ar_data",  bus.blk_data,       DW'(0));
    check("ar_len",   DW'(bus.blk_len),   DW'(0));
    check("ar_ready", DW'(bus.in_ready),  DW'(0));
    @(negedge enc_clk);
    rst = 1'b1; bus.blk_ready = 1'b1; m_reseed();

`ifdef ENC_SCRAMBLE_EN
    // Zero payload exposes the raw scrambler sequence
    bus.gen_speed = 2'd1;
    fill(0, 16, 4'd8, 8'h00, 8'h00, 8'h00);
    check("scr_zero_blk", bus.blk_data, exp3(1'b1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
